// File: rtl/fir_mac_sequencer_if.sv
// Handshake and datapath-control bundle between fir_mac_sequencer (master) and its MAC datapath (slave).
// Build option FIR_SEQ_STALL_EN adds the out_ready back-pressure signal.
interface fir_mac_sequencer_if #(
  parameter int AW = 5
);
  logic          in_valid;
  logic          in_ready;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic          zero_sample;
  logic [AW-1:0] rd_addr;
  logic [AW-1:0] coef_addr;
  logic          mac_clr;
  logic          mac_en;
  logic          mac_last;
  logic          out_valid;
  logic          frame_done;
  logic          busy;
`ifdef FIR_SEQ_STALL_EN
  logic          out_ready;

  modport master (
    input  in_valid, out_ready,
    output in_ready, wr_en, wr_addr, zero_sample, rd_addr, coef_addr,
           mac_clr, mac_en, mac_last, out_valid, frame_done, busy
  );
  modport slave (
    output in_valid, out_ready,
    input  in_ready, wr_en, wr_addr, zero_sample, rd_addr, coef_addr,
           mac_clr, mac_en, mac_last, out_valid, frame_done, busy
  );
`else
  modport master (
    input  in_valid,
    output in_ready, wr_en, wr_addr, zero_sample, rd_addr, coef_addr,
           mac_clr, mac_en, mac_last, out_valid, frame_done, busy
  );
  modport slave (
    output in_valid,
    input  in_ready, wr_en, wr_addr, zero_sample, rd_addr, coef_addr,
           mac_clr, mac_en, mac_last, out_valid, frame_done, busy
  );
`endif
endinterface

// File: rtl/fir_mac_sequencer.sv
// Time-multiplexed FIR scheduler: circular sample buffer writes, per-output MAC tap sweep, warm-up
// suppression and end-of-frame zero padding. Build option FIR_SEQ_STALL_EN holds valid outputs for out_ready.
//
// state  | meaning
// IDLE   | waiting for an input sample; accept writes it to the buffer
// MAC    | sweeping taps k=0..TAPS-1 through the shared accumulator
// OUT    | accumulator result presented (valid once warm-up is over)
// PADW   | writing a zero pad sample after the last real sample of a frame
module fir_mac_sequencer #(
  parameter int TAPS      = 32,
  parameter int AW        = 5,
  parameter int FRAME_LEN = 1024,
  parameter int CW        = 11
) (
  input logic           clk,
  input logic           rst,
  fir_mac_sequencer_if.master bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MAC  = 2'd1;
  localparam logic [1:0] S_OUT  = 2'd2;
  localparam logic [1:0] S_PADW = 2'd3;

  localparam logic [AW-1:0] K_LAST   = AW'(TAPS - 1);
  localparam logic [CW-1:0] IDX_WARM = CW'(TAPS - 1);
  localparam logic [CW-1:0] IDX_PAD  = CW'(FRAME_LEN - 1);
  localparam logic [CW-1:0] IDX_LAST = CW'(FRAME_LEN + TAPS - 2);

  logic [1:0]    state;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] base;
  logic [AW-1:0] k;
  logic [CW-1:0] idx;
  logic          accept;
  logic          out_ok;
  logic          out_adv;

  assign accept = (state == S_IDLE) && bus.in_valid;
  assign out_ok = (idx >= IDX_WARM);

`ifdef FIR_SEQ_STALL_EN
  // Warm-up results are discarded anyway, so only valid outputs wait for the consumer.
  assign out_adv = !out_ok || bus.out_ready;
`else
  assign out_adv = 1'b1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      wr_ptr <= '0;
      base   <= '0;
      k      <= '0;
      idx    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            base   <= wr_ptr;
            wr_ptr <= wr_ptr + 1'b1;
            state  <= S_MAC;
          end
        end
        S_MAC: begin
          if (k == K_LAST) begin
            k     <= '0;
            state <= S_OUT;
          end else begin
            k <= k + 1'b1;
          end
        end
        S_OUT: begin
          if (out_adv) begin
            if (idx == IDX_LAST) begin
              idx   <= '0;
              state <= S_IDLE;
            end else begin
              idx   <= idx + 1'b1;
              state <= (idx >= IDX_PAD) ? S_PADW : S_IDLE;
            end
          end
        end
        S_PADW: begin
          base   <= wr_ptr;
          wr_ptr <= wr_ptr + 1'b1;
          state  <= S_MAC;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Newest sample pairs with coefficient 0; addresses are parked at 0 outside the sweep.
  assign bus.in_ready    = (state == S_IDLE);
  assign bus.wr_en       = accept || (state == S_PADW);
  assign bus.wr_addr     = wr_ptr;
  assign bus.zero_sample = (state == S_PADW);
  assign bus.mac_en      = (state == S_MAC);
  assign bus.rd_addr     = (state == S_MAC) ? (base - k) : '0;
  assign bus.coef_addr   = (state == S_MAC) ? k : '0;
  assign bus.mac_clr     = (state == S_MAC) && (k == '0);
  assign bus.mac_last    = (state == S_MAC) && (k == K_LAST);
  assign bus.out_valid   = (state == S_OUT) && out_ok;
  assign bus.frame_done  = (state == S_OUT) && (idx == IDX_LAST);
  assign bus.busy        = (state != S_IDLE);

endmodule

// File: doc/fir_mac_sequencer.md
Name: fir_mac_sequencer

Overview:
- Scheduler for a time-multiplexed FIR: one shared multiply-accumulate unit plus a TAPS-deep sample RAM and coefficient ROM replace the fully parallel tap array.
- Accepts input samples by valid/ready handshake and writes each into a circular sample buffer.
- Steps the shared MAC through all taps, suppresses warm-up outputs and appends TAPS-1 zero pad samples per frame, so each frame yields exactly FRAME_LEN outputs.

Parameters:
- TAPS, 32, filter length; power of two.
- AW, 5, log2(TAPS); width of buffer/coefficient addresses.
- FRAME_LEN, 1024, real input samples per frame.
- CW, 11, sample-index counter width; must satisfy 2^CW > FRAME_LEN+TAPS-1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  input sample offered.
- in_ready  out  1  sequencer can accept a sample.
- wr_en  out  1  write strobe to sample RAM.
- wr_addr  out  AW  sample RAM write address (circular pointer).
- zero_sample  out  1  datapath writes 0 instead of input data.
- rd_addr  out  AW  sample RAM read address.
- coef_addr  out  AW  coefficient ROM address.
- mac_clr  out  1  accumulator loads product instead of adding.
- mac_en  out  1  accumulator update enable.
- mac_last  out  1  final tap of current output.
- out_valid  out  1  accumulator holds a valid filter output.
- frame_done  out  1  coincides with last out_valid of a frame.
- busy  out  1  high in any state except IDLE.

Behaviour:
- Reset: state IDLE, wr_ptr=0, tap counter k=0, sample index idx=0. All outputs 0 except in_ready=1.
- States:
  - IDLE: in_ready=1. On in_valid&&in_ready: wr_en=1, wr_addr=wr_ptr, zero_sample=0; latch base=wr_ptr; wr_ptr<=wr_ptr+1 (mod TAPS); go MAC.
  - MAC: in_ready=0. For k=0..TAPS-1, one per cycle: mac_en=1; rd_addr=(base-k) mod TAPS (newest sample first); coef_addr=k; mac_clr=1 only at k=0; mac_last=1 only at k=TAPS-1. After k=TAPS-1 go OUT; k returns to 0.
  - OUT: single cycle. out_valid=1 iff idx>=TAPS-1 (warm-up suppression). frame_done=1 iff idx==FRAME_LEN+TAPS-2. Next state:
    - idx==FRAME_LEN+TAPS-2: go IDLE, idx<=0.
    - idx>=FRAME_LEN-1: go PADW, idx<=idx+1.
    - otherwise: go IDLE, idx<=idx+1.
  - PADW: in_ready=0; wr_en=1, zero_sample=1, wr_addr=wr_ptr; latch base; advance wr_ptr; go MAC.
- Timing: sample accepted at cycle t; MAC runs t+1..t+TAPS; OUT at t+TAPS+1. Accumulator result is valid in the OUT cycle. Minimum input spacing is TAPS+2 cycles.
- Per frame: FRAME_LEN+TAPS-1 writes and exactly FRAME_LEN out_valid pulses.
- Wrap-around: wr_ptr and rd_addr are modulo TAPS. The buffer is not cleared between frames; warm-up suppression hides stale contents.
- in_valid is ignored outside IDLE. No data is lost because in_ready is 0 there.
- Reset mid-MAC or mid-pad: abort immediately. The next accepted sample is idx 0 at wr_addr 0.
- No simultaneous write and MAC read occurs; wr_en and mac_en are mutually exclusive.

Optional Feature:
- Macro FIR_SEQ_STALL_EN.
- Defined: adds input port out_ready (1 bit). OUT holds with out_valid=1 (frame_done held alongside when applicable) until out_ready=1. idx update and the state transition occur in the handshake cycle. Invalid (warm-up) OUT cycles advance without waiting.
- Undefined: no out_ready port; OUT always lasts one cycle.

Test Plan:
- Reset, then one sample -> wr_en with wr_addr=0 at accept; mac_clr only on first MAC cycle; mac_last on 32nd cycle; out_valid=0 (idx 0 is warm-up); in_ready back to 1 at t+34.
- 40 back-to-back samples with in_valid held high -> accepts spaced 34 cycles apart; first out_valid follows sample idx 31; rd_addr sequence for idx 33 is 1,0,31,30,... with coef_addr 0..31.
- Full frame of 1024 samples -> 31 PADW writes with zero_sample=1 and in_ready=0; exactly 1024 out_valid pulses; frame_done on the 1024th only; idx returns to 0.
- TAPS=4, AW=2, FRAME_LEN=8, CW=4 -> 11 writes, 8 outputs, wr_addr wraps 3->0, next frame starts with warm-up again.
- Assert rst during MAC of idx 5 -> outputs zero immediately; next sample written at addr 0 with no out_valid.
- With FIR_SEQ_STALL_EN and out_ready=0 for 10 cycles at a valid OUT -> out_valid held 11 cycles; in_ready stays 0; idx advances once.
